// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-word layout,
// forwarding-mux select encodings and the hard-wired zero register.
package mips_pkg;

    // Packed control word, MSB first:
    // {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[3:0]}
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_op;
    } ctl_t;

    localparam int CTL_W = $bits(ctl_t);

    // Bit offsets of the control fields inside the packed word
    localparam int CTL_REG_WRITE = 9;
    localparam int CTL_MEM_READ  = 7;

    // Select encodings for the EX operand 3:1 muxes
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // $0 is hard-wired to zero and never forwarded or hazard-checked
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX operand. EX/MEM wins over MEM/WB because
// it carries the newer value; $0 is never forwarded; bubbles select the
// ID/EX register path.
module fwd_sel
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_we_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_we_i,
    input  logic              valid_i,
    output logic [1:0]        sel_o
);

    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

    // Priority compare: EX/MEM first, then MEM/WB, else register data
    always_comb begin
        sel_o = FWD_REG;
        if (valid_i) begin
            if (exmem_we_i && (exmem_rd_i != ZERO_REG) && (exmem_rd_i == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (memwb_we_i && (memwb_rd_i != ZERO_REG) && (memwb_rd_i == src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with EX-side forwarding selects and load-use
// hazard detection. A load in EX whose rt feeds the instruction in ID
// raises a one-cycle stall and a bubble is loaded instead.
module id_ex_fwd_stage
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTL_W  = mips_pkg::CTL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTL_W-1:0]  id_ctl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    output logic              ex_valid,
    output logic [CTL_W-1:0]  ex_ctl,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    import mips_pkg::*;

    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

    logic              ex_valid_q, ex_valid_d;
    logic [CTL_W-1:0]  ex_ctl_q,   ex_ctl_d;
    logic [REG_AW-1:0] ex_rs_q,    ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,    ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
    logic [DATA_W-1:0] ex_rd1_q,   ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q,   ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              load_use;
    logic              bubble;

    // Load in EX whose destination (rt) is a source of the valid ID instruction
    always_comb begin
        load_use = ex_valid_q && ex_ctl_q[CTL_MEM_READ] && id_valid
                   && (ex_rt_q != ZERO_REG)
                   && ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    end

    // Next-state: data fields always follow ID; flush or stall turns the slot into a bubble
    always_comb begin
        bubble      = flush || load_use;
        ex_rs_d     = id_rs;
        ex_rt_d     = id_rt;
        ex_rd_d     = id_rd;
        ex_rd1_d    = id_rd1;
        ex_rd2_d    = id_rd2;
        ex_imm_d    = id_imm;
        ex_valid_d  = id_valid && !bubble;
        ex_ctl_d    = ex_valid_d ? id_ctl : '0;
        stall_cnt_d = stall_cnt_q;
        // flush already squashes the slot, so a coincident stall is not counted
        if (load_use && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // ID/EX register and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctl_q    <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_rd1_q    <= '0;
            ex_rd2_q    <= '0;
            ex_imm_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctl_q    <= ex_ctl_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_rd1_q    <= ex_rd1_d;
            ex_rd2_q    <= ex_rd2_d;
            ex_imm_q    <= ex_imm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i      (ex_rs_q),
        .exmem_rd_i (exmem_rd),
        .exmem_we_i (exmem_reg_write),
        .memwb_rd_i (memwb_rd),
        .memwb_we_i (memwb_reg_write),
        .valid_i    (ex_valid_q),
        .sel_o      (ex_fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i      (ex_rt_q),
        .exmem_rd_i (exmem_rd),
        .exmem_we_i (exmem_reg_write),
        .memwb_rd_i (memwb_rd),
        .memwb_we_i (memwb_reg_write),
        .valid_i    (ex_valid_q),
        .sel_o      (ex_fwd_b)
    );

    assign ex_valid    = ex_valid_q;
    assign ex_ctl      = ex_ctl_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_imm      = ex_imm_q;
    assign stall       = load_use;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: reset, capture, forwarding priority,
// load-use stall, flush/stall interaction, counter saturation (small
// counter width) and asynchronous reset during a stall.
module tb_id_ex_fwd_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTL_W  = 10;
    localparam int CNT_W  = 4;

    // lw: reg_write|mem_to_reg|mem_read|alu_src, alu_op 0
    localparam logic [CTL_W-1:0] CTL_LW  = 10'h3A0;
    // R-type add: reg_write|reg_dst, alu_op 2
    localparam logic [CTL_W-1:0] CTL_ADD = 10'h212;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [CTL_W-1:0]  id_ctl;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic              flush;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_reg_write;
    logic              ex_valid;
    logic [CTL_W-1:0]  ex_ctl;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [1:0]        ex_fwd_a, ex_fwd_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    int pass_cnt = 0;
    int total    = 0;

    id_ex_fwd_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CTL_W  (CTL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_ctl          (id_ctl),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rd1          (id_rd1),
        .id_rd2          (id_rd2),
        .id_imm          (id_imm),
        .flush           (flush),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .ex_valid        (ex_valid),
        .ex_ctl          (ex_ctl),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_rd1          (ex_rd1),
        .ex_rd2          (ex_rd2),
        .ex_imm          (ex_imm),
        .ex_fwd_a        (ex_fwd_a),
        .ex_fwd_b        (ex_fwd_b),
        .stall           (stall),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [CTL_W-1:0] ctl,
                            input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                            input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] d1,
                            input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] imm);
        id_valid = v;
        id_ctl   = ctl;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_rd1   = d1;
        id_rd2   = d2;
        id_imm   = imm;
    endtask

    task automatic drive_wb(input logic [REG_AW-1:0] erd, input logic ewe,
                            input logic [REG_AW-1:0] mrd, input logic mwe);
        exmem_rd        = erd;
        exmem_reg_write = ewe;
        memwb_rd        = mrd;
        memwb_reg_write = mwe;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive_id(1'b1, CTL_W'($urandom), REG_AW'($urandom), REG_AW'($urandom),
                 REG_AW'($urandom), $urandom, $urandom, $urandom);
        drive_wb(REG_AW'($urandom), 1'b1, REG_AW'($urandom), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", ex_valid); else pass_cnt++;
        total++; if (ex_ctl !== '0) $display("FAIL reset_ctl got=%0h exp=0", ex_ctl); else pass_cnt++;
        total++; if ({ex_rs, ex_rt, ex_rd} !== '0) $display("FAIL reset_regs got=%0h exp=0", {ex_rs, ex_rt, ex_rd}); else pass_cnt++;
        total++; if ({ex_rd1, ex_rd2, ex_imm} !== '0) $display("FAIL reset_data got=%0h exp=0", {ex_rd1, ex_rd2, ex_imm}); else pass_cnt++;
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'h0) $display("FAIL reset_fwd got=%0h exp=0", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0h exp=0", stall); else pass_cnt++;
        total++; if (stall_count !== '0) $display("FAIL reset_count got=%0h exp=0", stall_count); else pass_cnt++;

        drive_id(1'b1, CTL_ADD, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h55, 32'hFFFF_FFF0);
        drive_wb(5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        tick();
        total++; if (ex_rd1 !== 32'h1234) $display("FAIL release_rd1 got=%0h exp=1234", ex_rd1); else pass_cnt++;
        total++; if (ex_valid !== 1'b1) $display("FAIL release_valid got=%0h exp=1", ex_valid); else pass_cnt++;
    endtask

    task automatic test_capture();
        drive_id(1'b1, CTL_ADD, 5'd10, 5'd11, 5'd12, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0007);
        tick();
        total++; if (ex_ctl !== CTL_ADD) $display("FAIL cap_ctl got=%0h exp=%0h", ex_ctl, CTL_ADD); else pass_cnt++;
        total++; if ({ex_rs, ex_rt, ex_rd} !== {5'd10, 5'd11, 5'd12}) $display("FAIL cap_regs got=%0h exp=%0h", {ex_rs, ex_rt, ex_rd}, {5'd10, 5'd11, 5'd12}); else pass_cnt++;
        total++; if ({ex_rd2, ex_imm} !== {32'hBBBB_0002, 32'h7}) $display("FAIL cap_data got=%0h exp=%0h", {ex_rd2, ex_imm}, {32'hBBBB_0002, 32'h7}); else pass_cnt++;
        // invalid ID instruction: control word is zeroed
        drive_id(1'b0, CTL_ADD, 5'd4, 5'd4, 5'd4, 32'h1, 32'h2, 32'h3);
        tick();
        total++; if ({ex_valid, ex_ctl} !== 11'h0) $display("FAIL cap_invalid got=%0h exp=0", {ex_valid, ex_ctl}); else pass_cnt++;
        // flush with no hazard: bubble
        drive_id(1'b1, CTL_ADD, 5'd4, 5'd4, 5'd4, 32'h1, 32'h2, 32'h3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if ({ex_valid, ex_ctl} !== 11'h0) $display("FAIL flush_bubble got=%0h exp=0", {ex_valid, ex_ctl}); else pass_cnt++;
    endtask

    task automatic test_forwarding();
        drive_id(1'b1, CTL_ADD, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0);
        drive_wb(5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive_wb(5'd5, 1'b1, 5'd5, 1'b1);
        #1;
        total++; if (ex_fwd_a !== 2'd1) $display("FAIL fwd_a_prio got=%0d exp=1", ex_fwd_a); else pass_cnt++;
        total++; if (ex_fwd_b !== 2'd0) $display("FAIL fwd_b_none got=%0d exp=0", ex_fwd_b); else pass_cnt++;
        drive_wb(5'd5, 1'b0, 5'd5, 1'b1);
        #1;
        total++; if (ex_fwd_a !== 2'd2) $display("FAIL fwd_a_memwb got=%0d exp=2", ex_fwd_a); else pass_cnt++;
        drive_wb(5'd9, 1'b1, 5'd6, 1'b1);
        #1;
        total++; if ({ex_fwd_a, ex_fwd_b} !== {2'd0, 2'd2}) $display("FAIL fwd_b_memwb got=%0h exp=2", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;
        drive_wb(5'd6, 1'b1, 5'd6, 1'b1);
        #1;
        total++; if (ex_fwd_b !== 2'd1) $display("FAIL fwd_b_prio got=%0d exp=1", ex_fwd_b); else pass_cnt++;

        // $0 is never forwarded
        drive_id(1'b1, CTL_ADD, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0);
        drive_wb(5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive_wb(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'h0) $display("FAIL fwd_zero got=%0h exp=0", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;

        // bubble in EX: selects forced to register path
        drive_id(1'b0, CTL_ADD, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0);
        drive_wb(5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive_wb(5'd5, 1'b1, 5'd6, 1'b1);
        #1;
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'h0) $display("FAIL fwd_invalid got=%0h exp=0", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;
        drive_wb(5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_load_use();
        drive_id(1'b1, CTL_LW, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4);
        tick();
        drive_id(1'b1, CTL_ADD, 5'd8, 5'd3, 5'd9, 32'h0, 32'h33, 32'h0);
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_stall got=%0h exp=1", stall); else pass_cnt++;
        tick();
        total++; if ({ex_valid, ex_ctl} !== 11'h0) $display("FAIL lu_bubble got=%0h exp=0", {ex_valid, ex_ctl}); else pass_cnt++;
        total++; if (stall_count !== 4'd1) $display("FAIL lu_count got=%0d exp=1", stall_count); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL lu_one_cycle got=%0h exp=0", stall); else pass_cnt++;
        // load now in MEM/WB, bubble in EX/MEM
        drive_wb(5'd0, 1'b0, 5'd8, 1'b1);
        tick();
        total++; if ({ex_valid, ex_ctl, ex_rs} !== {1'b1, CTL_ADD, 5'd8}) $display("FAIL lu_add_enters got=%0h exp=%0h", {ex_valid, ex_ctl, ex_rs}, {1'b1, CTL_ADD, 5'd8}); else pass_cnt++;
        total++; if ({ex_fwd_a, ex_fwd_b} !== {2'd2, 2'd0}) $display("FAIL lu_fwd got=%0h exp=8", {ex_fwd_a, ex_fwd_b}); else pass_cnt++;
        drive_wb(5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_flush_vs_stall();
        drive_id(1'b1, CTL_LW, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4);
        tick();
        drive_id(1'b1, CTL_ADD, 5'd3, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL fs_stall got=%0h exp=1", stall); else pass_cnt++;
        tick();
        flush = 1'b0;
        total++; if ({ex_valid, ex_ctl} !== 11'h0) $display("FAIL fs_bubble got=%0h exp=0", {ex_valid, ex_ctl}); else pass_cnt++;
        total++; if (stall_count !== 4'd1) $display("FAIL fs_count got=%0d exp=1", stall_count); else pass_cnt++;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL fs_next_nostall got=%0h exp=0", stall); else pass_cnt++;
    endtask

    task automatic test_saturation();
        // 2^CNT_W + 3 stalls starting from a count of 1
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            drive_id(1'b1, CTL_LW, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0);
            tick();
            drive_id(1'b1, CTL_ADD, 5'd8, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0);
            tick();
        end
        total++; if (stall_count !== 4'hF) $display("FAIL sat_count got=%0h exp=f", stall_count); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive_id(1'b1, CTL_LW, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        drive_id(1'b1, CTL_ADD, 5'd8, 5'd3, 5'd9, 32'h0, 32'h0, 32'h0);
        #1;
        total++; if (stall !== 1'b1) $display("FAIL ar_pre_stall got=%0h exp=1", stall); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total++; if ({ex_valid, ex_ctl, stall} !== 12'h0) $display("FAIL ar_clear got=%0h exp=0", {ex_valid, ex_ctl, stall}); else pass_cnt++;
        total++; if (stall_count !== '0) $display("FAIL ar_count got=%0h exp=0", stall_count); else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forwarding();
        test_load_use();
        test_flush_vs_stall();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
